// File: rtl/coil_fire_sequencer_pkg.sv
// Shared types and bit positions for the coil fire sequencer: FSM states,
// control-register bit indices and sticky-flag bit indices.
package coil_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    DELAY    = 3'd2,
    PULSE    = 3'd3,
    COOLDOWN = 3'd4,
    FAULT    = 3'd5
  } state_t;

  // control register bits
  localparam int ARM  = 0;
  localparam int FIRE = 1;
  localparam int CLR  = 2;

  // sticky flag bits
  localparam int DONE  = 0;
  localparam int TMO   = 1;
  localparam int CFG   = 2;
  localparam int UNARM = 3;
  localparam int STUCK = 4;
  localparam int ABORT = 5;
  localparam int CAP   = 6;

endpackage

// File: rtl/coil_fire_sequencer_if.sv
// Register-side bundle between the I2C register file and the coil sequencer,
// plus the projectile sensor input and a debug view of the FSM state.
interface coil_fire_sequencer_if;
  import coil_pkg::*;

  // Level-sampled register interface, no handshake: inputs are read every
  // I_clk edge, outputs are registered and valid every cycle after reset.
  logic [7:0]  I_creg;
  logic [23:0] I_dly;
  logic [23:0] I_lmt;
  logic        I_sensor;
  logic        O_coil;
  logic [7:0]  O_eflg;
  logic [23:0] O_acc;
  logic        O_busy;
  state_t      O_state;

  modport slave (
    input  I_creg, I_dly, I_lmt, I_sensor,
    output O_coil, O_eflg, O_acc, O_busy, O_state
  );

  modport master (
    output I_creg, I_dly, I_lmt, I_sensor,
    input  O_coil, O_eflg, O_acc, O_busy, O_state
  );

endinterface

// File: rtl/coil_fire_sequencer_sync.sv
// STAGES-deep flip-flop synchronizer for an asynchronous single-bit input;
// all stages clear to 0 under synchronous active-low reset.
module coil_sync #(
  parameter int STAGES = 2
) (
  input  logic I_clk,
  input  logic I_rst_n,
  input  logic I_d,
  output logic O_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], I_d};
    end
  end

  assign O_q = r_sync[STAGES-1];

endmodule

// File: rtl/coil_fire_sequencer.sv
// Single-shot coil fire sequencer: arm, delayed fire, sensor/limit-terminated
// pulse, cooldown. Optional absolute pulse cap enabled by COIL_HARDCAP_EN.
module coil_fire_sequencer
  import coil_pkg::*;
#(
  parameter int COOLDOWN_CYC  = 1000,
  parameter int MAX_PULSE_CYC = 50000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                  I_clk,
  input  logic                  I_rst_n,
  coil_fire_sequencer_if.slave  bus
);

  localparam logic [23:0] COOL_LAST = 24'(COOLDOWN_CYC - 1);

  if (COOLDOWN_CYC < 1 || SYNC_STAGES < 2 || MAX_PULSE_CYC < 1 ||
      MAX_PULSE_CYC > 16777215) begin : g_bad_param
    $error("coil_fire_sequencer: parameter out of range");
  end

  state_t      r_state, w_state_nxt;
  logic [23:0] r_cnt, w_cnt_nxt;
  logic [23:0] r_dly_q, w_dly_nxt;
  logic [23:0] r_lmt_q, w_lmt_nxt;
  logic [23:0] r_acc, w_acc_nxt;
  logic [7:0]  r_eflg, w_eflg_nxt;
  logic        r_coil, w_coil_nxt;
  logic        r_first, w_first_nxt;
  logic        r_prev_fire;

  logic        w_sens_s;
  logic        w_arm, w_fire_e, w_clr;
  logic [24:0] w_acc_p1;
  logic [23:0] w_eff_lmt;
  logic        w_cap_hit;
  logic        w_unused_creg;

  coil_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .I_d     (bus.I_sensor),
    .O_q     (w_sens_s)
  );

  assign w_arm         = bus.I_creg[ARM];
  assign w_clr         = bus.I_creg[CLR];
  assign w_fire_e      = bus.I_creg[FIRE] & ~r_prev_fire;
  assign w_unused_creg = ^bus.I_creg[7:3];
  assign w_acc_p1      = {1'b0, r_acc} + 25'd1;

`ifdef COIL_HARDCAP_EN
  localparam logic [23:0] CAP_LMT = 24'(MAX_PULSE_CYC);
  assign w_cap_hit = (CAP_LMT < r_lmt_q);
  assign w_eff_lmt = w_cap_hit ? CAP_LMT : r_lmt_q;
`else
  assign w_cap_hit = 1'b0;
  assign w_eff_lmt = r_lmt_q;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dly_nxt   = r_dly_q;
    w_lmt_nxt   = r_lmt_q;
    w_acc_nxt   = r_acc;
    w_first_nxt = 1'b0;
    // a flag set below overrides a clear held in the same cycle
    w_eflg_nxt  = w_clr ? 8'h00 : r_eflg;

    unique case (r_state)
      IDLE: begin
        if (w_arm) begin
          w_state_nxt = ARMED;
        end else if (w_fire_e) begin
          w_eflg_nxt[UNARM] = 1'b1;
        end
      end
      ARMED: begin
        if (!w_arm) begin
          w_state_nxt = IDLE;
        end else if (w_fire_e) begin
          w_dly_nxt = bus.I_dly;
          w_lmt_nxt = bus.I_lmt;
          if (bus.I_lmt == 24'd0) begin
            w_eflg_nxt[CFG] = 1'b1;
            w_state_nxt     = FAULT;
          end else begin
            w_cnt_nxt   = 24'd0;
            w_state_nxt = DELAY;
          end
        end
      end
      DELAY: begin
        if (!w_arm) begin
          w_eflg_nxt[ABORT] = 1'b1;
          w_state_nxt       = IDLE;
        end else if (r_cnt == r_dly_q) begin
          w_cnt_nxt   = 24'd0;
          w_acc_nxt   = 24'd0;
          w_first_nxt = 1'b1;
          w_state_nxt = PULSE;
        end else begin
          w_cnt_nxt = r_cnt + 24'd1;
        end
      end
      PULSE: begin
        w_acc_nxt = (&r_acc) ? r_acc : w_acc_p1[23:0];
        if (!w_arm) begin
          w_eflg_nxt[ABORT] = 1'b1;
          w_state_nxt       = IDLE;
        end else if (w_sens_s && r_first) begin
          w_eflg_nxt[STUCK] = 1'b1;
          w_state_nxt       = FAULT;
        end else if (w_sens_s) begin
          w_eflg_nxt[DONE] = 1'b1;
          w_cnt_nxt        = 24'd0;
          w_state_nxt      = COOLDOWN;
        end else if (w_acc_p1 == {1'b0, w_eff_lmt}) begin
          w_eflg_nxt[TMO] = 1'b1;
          w_eflg_nxt[CAP] = w_eflg_nxt[CAP] | w_cap_hit;
          w_state_nxt     = FAULT;
        end
      end
      COOLDOWN: begin
        if (r_cnt == COOL_LAST) begin
          w_cnt_nxt   = 24'd0;
          w_state_nxt = w_arm ? ARMED : IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 24'd1;
        end
      end
      FAULT: begin
        if (w_clr) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Coil is driven only while the FSM stays in PULSE across the edge, so it
    // can never be high in any other state, and drops on the leaving edge.
    w_coil_nxt = (r_state == PULSE) && (w_state_nxt == PULSE);
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 24'd0;
      r_dly_q     <= 24'd0;
      r_lmt_q     <= 24'd0;
      r_acc       <= 24'd0;
      r_eflg      <= 8'h00;
      r_coil      <= 1'b0;
      r_first     <= 1'b0;
      r_prev_fire <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_dly_q     <= w_dly_nxt;
      r_lmt_q     <= w_lmt_nxt;
      r_acc       <= w_acc_nxt;
      r_eflg      <= {1'b0, w_eflg_nxt[6:0]};
      r_coil      <= w_coil_nxt;
      r_first     <= w_first_nxt;
      r_prev_fire <= bus.I_creg[FIRE];
    end
  end

  assign bus.O_coil  = r_coil;
  assign bus.O_eflg  = r_eflg;
  assign bus.O_acc   = r_acc;
  assign bus.O_state = r_state;
  assign bus.O_busy  = (r_state == DELAY) || (r_state == PULSE) ||
                       (r_state == COOLDOWN);

endmodule

// File: tb/tb_coil_fire_sequencer.sv
// Directed bench for coil_fire_sequencer; the cap scenario runs only when
// COIL_HARDCAP_EN is defined.
module tb_coil_fire_sequencer;
  import coil_pkg::*;

  localparam int COOL = 1000;
  localparam int MAXP = 30;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   fire_cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  // {state, eflg, acc} at each flag change; {rise offset, width} per coil
  // pulse; busy-high width per shot
  logic [34:0] exp_flag_q[$];
  logic [31:0] exp_coil_q[$];
  logic [15:0] exp_busy_q[$];

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  coil_fire_sequencer_if bus();

  coil_fire_sequencer #(
    .COOLDOWN_CYC  (COOL),
    .MAX_PULSE_CYC (MAXP),
    .SYNC_STAGES   (2)
  ) dut (
    .I_clk   (clk),
    .I_rst_n (rst_n),
    .bus     (bus)
  );

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fire(input logic [23:0] dly, input logic [23:0] lmt);
    bus.I_dly  = dly;
    bus.I_lmt  = lmt;
    bus.I_creg = 8'h03;
    fire_cyc   = cyc + 1;
  endtask

  function automatic void exp_flag(input state_t s, input logic [7:0] f,
                                   input logic [23:0] a);
    exp_flag_q.push_back({s, f, a});
  endfunction

  function automatic void exp_shot(input int off, input int width, input int busy);
    exp_coil_q.push_back({16'(off), 16'(width)});
    exp_busy_q.push_back(16'(busy));
  endfunction

  // monitor / scoreboard
  logic       prev_coil = 1'b0;
  logic       prev_busy = 1'b0;
  logic [7:0] prev_eflg = 8'h00;
  int         coil_w = 0;
  int         busy_w = 0;
  int         rise_off = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.O_coil) check("coil_only_in_pulse", 64'(bus.O_state), 64'(PULSE));
      if (bus.O_coil && !prev_coil) begin
        rise_off = cyc - fire_cyc;
        coil_w   = 1;
      end else if (bus.O_coil) begin
        coil_w++;
      end
      if (!bus.O_coil && prev_coil) begin
        if (exp_coil_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL coil_pulse: unexpected pulse off=%0d width=%0d", rise_off, coil_w);
        end else begin
          check("coil_pulse", {16'(rise_off), 16'(coil_w)}, exp_coil_q.pop_front());
        end
      end

      if (bus.O_busy) busy_w = prev_busy ? busy_w + 1 : 1;
      if (!bus.O_busy && prev_busy) begin
        if (exp_busy_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL busy_width: unexpected busy window width=%0d", busy_w);
        end else begin
          check("busy_width", 64'(busy_w), 64'(exp_busy_q.pop_front()));
        end
      end

      if (bus.O_eflg !== prev_eflg) begin
        if (exp_flag_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL flag_event: unexpected eflg=%0h acc=%0d", bus.O_eflg, bus.O_acc);
        end else begin
          check("flag_event", {bus.O_state, bus.O_eflg, bus.O_acc}, exp_flag_q.pop_front());
        end
      end
      prev_coil = bus.O_coil;
      prev_busy = bus.O_busy;
      prev_eflg = bus.O_eflg;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.I_creg   = 8'h00;
    bus.I_dly    = 24'd0;
    bus.I_lmt    = 24'd0;
    bus.I_sensor = 1'b0;
    rst_n = 1'b0;
    tick(3);
    check("rst_coil",  64'(bus.O_coil), 64'd0);
    check("rst_eflg",  64'(bus.O_eflg), 64'd0);
    check("rst_acc",   64'(bus.O_acc),  64'd0);
    check("rst_busy",  64'(bus.O_busy), 64'd0);
    check("rst_state", 64'(bus.O_state), 64'(IDLE));
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // sensor terminates after 20 pulse cycles; coil rises at fire edge + 7
    bus.I_creg = 8'h01; tick(2);
    fire(24'd5, 24'd100);
    exp_shot(7, 19, 6 + 20 + COOL);
    exp_flag(COOLDOWN, 8'h01, 24'd20);
    tick(1); bus.I_creg = 8'h01;
    tick(23); bus.I_sensor = 1'b1;
    tick(5);  bus.I_sensor = 1'b0;
    tick(1040);

    // limit timeout with zero delay, then clear out of FAULT
    bus.I_creg = 8'h05; exp_flag(ARMED, 8'h00, 24'd20);
    tick(1); bus.I_creg = 8'h01; tick(1);
    fire(24'd0, 24'd10);
    exp_shot(2, 9, 1 + 10);
    exp_flag(FAULT, 8'h02, 24'd10);
    tick(1); bus.I_creg = 8'h01; tick(20);
    bus.I_creg = 8'h05; exp_flag(IDLE, 8'h00, 24'd10);
    tick(1); bus.I_creg = 8'h01; tick(2);

    // zero limit is a config error; fire while unarmed
    fire(24'd4, 24'd0);
    exp_flag(FAULT, 8'h04, 24'd10);
    tick(1); bus.I_creg = 8'h01; tick(3);
    bus.I_creg = 8'h04; exp_flag(IDLE, 8'h00, 24'd10);
    tick(1); bus.I_creg = 8'h00; tick(2);
    bus.I_creg = 8'h02; exp_flag(IDLE, 8'h08, 24'd10);
    tick(1); bus.I_creg = 8'h00; tick(3);
    bus.I_creg = 8'h04; exp_flag(IDLE, 8'h00, 24'd10);
    tick(1); bus.I_creg = 8'h00; tick(2);

    // arm dropped during the third pulse cycle
    bus.I_creg = 8'h01; tick(2);
    fire(24'd2, 24'd100);
    exp_shot(4, 2, 3 + 3);
    exp_flag(IDLE, 8'h20, 24'd3);
    tick(1); bus.I_creg = 8'h01;
    tick(5); bus.I_creg = 8'h00;
    tick(4);
    bus.I_creg = 8'h04; exp_flag(IDLE, 8'h00, 24'd3);
    tick(1); bus.I_creg = 8'h00; tick(2);

    // reset in the middle of a pulse
    bus.I_creg = 8'h01; tick(2);
    fire(24'd1, 24'd100);
    exp_shot(3, 2, 5);
    tick(1); bus.I_creg = 8'h01;
    tick(4); rst_n = 1'b0; bus.I_creg = 8'h00;
    tick(1);
    check("midrst_coil",  64'(bus.O_coil), 64'd0);
    check("midrst_eflg",  64'(bus.O_eflg), 64'd0);
    check("midrst_acc",   64'(bus.O_acc),  64'd0);
    check("midrst_busy",  64'(bus.O_busy), 64'd0);
    check("midrst_state", 64'(bus.O_state), 64'(IDLE));
    tick(1); rst_n = 1'b1; tick(2);

    // sensor and limit on the same cycle; registers rewritten during DELAY
    bus.I_creg = 8'h01; tick(2);
    fire(24'd3, 24'd12);
    exp_shot(5, 11, 4 + 12 + COOL);
    exp_flag(COOLDOWN, 8'h01, 24'd12);
    tick(1); bus.I_creg = 8'h01; bus.I_dly = 24'd50; bus.I_lmt = 24'd5;
    tick(13); bus.I_sensor = 1'b1;
    tick(4);  bus.I_sensor = 1'b0;
    tick(1030);
    bus.I_creg = 8'h05; exp_flag(ARMED, 8'h00, 24'd12);
    tick(1); bus.I_creg = 8'h01; tick(1);

`ifdef COIL_HARDCAP_EN
    // absolute cap binds below the programmed limit
    fire(24'd0, 24'd100);
    exp_shot(2, MAXP - 1, 1 + MAXP);
    exp_flag(FAULT, 8'h42, 24'(MAXP));
    tick(1); bus.I_creg = 8'h01; tick(MAXP + 10);
    bus.I_creg = 8'h05; exp_flag(IDLE, 8'h00, 24'(MAXP));
    tick(1); bus.I_creg = 8'h01; tick(2);
`endif

    for (int i = 0; i < 100; i++) begin
      if (exp_flag_q.size() + exp_coil_q.size() + exp_busy_q.size() == 0) break;
      tick(1);
    end
    check("flag_events_left", 64'(exp_flag_q.size()), 64'd0);
    check("coil_pulses_left", 64'(exp_coil_q.size()), 64'd0);
    check("busy_windows_left", 64'(exp_busy_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
